// File: rtl/cr_clic_arb_sched.sv
// cr_clic_arb_sched: multi-cycle CLIC interrupt arbiter/scheduler.
// Finds the highest-level pending & enabled source above the threshold and
// offers it to the core over a valid/ack handshake. After the core accepts,
// it pulses a one-hot claim-clear back to the pending register file.
// Optional feature macro: CLIC_ARB_RR_EN selects round-robin among sources
// tied at the maximum level. If the macro is undefined, the highest index wins.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing offered; waits for any eligible source
// SCAN    | one cycle: picks max level, breaks ties, latches id/lvl/one-hot
// REQ     | winner offered (arb_req_vld=1); waits for ack, retract or preempt
// CLAIM   | one-cycle core_claim_clr pulse for the accepted source

module cr_clic_arb_sched #(
    parameter int NUM_INT = 32,
    parameter int LVL_W   = 8,
    parameter int ID_W    = 5
) (
    input  logic                     clic_clk,
    input  logic                     clic_rst,
    input  logic [NUM_INT-1:0]       int_pending,
    input  logic [NUM_INT-1:0]       int_enable,
    input  logic [NUM_INT*LVL_W-1:0] int_level,
    input  logic [LVL_W-1:0]         int_thresh,
    output logic                     arb_req_vld,
    output logic [ID_W-1:0]          arb_req_id,
    output logic [LVL_W-1:0]         arb_req_lvl,
    input  logic                     core_ack,
    output logic [NUM_INT-1:0]       core_claim_clr,
    output logic                     arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_REQ   = 2'd2,
        S_CLAIM = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ID_W-1:0]      r_id;
    logic [LVL_W-1:0]     r_lvl;
    logic [NUM_INT-1:0]   r_onehot;

    logic [NUM_INT-1:0]   w_elig;
    logic                 w_any_elig;
    logic [LVL_W-1:0]     w_maxlvl;
    logic [NUM_INT-1:0]   w_cand;
    logic [ID_W-1:0]      w_hi_id;
    logic [ID_W-1:0]      w_win_id;
    logic [NUM_INT-1:0]   w_win_oh;
    logic                 w_lat_elig;
    logic                 w_preempt;

`ifdef CLIC_ARB_RR_EN
    logic [ID_W-1:0]      r_last_id;
    logic [NUM_INT-1:0]   w_lo;
    logic [ID_W-1:0]      w_lo_id;
`endif

    // Eligibility: pending, enabled and strictly above the threshold.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_elig[i] = int_pending[i] & int_enable[i] &
                        (int_level[i*LVL_W +: LVL_W] > int_thresh);
        end
    end

    assign w_any_elig = |w_elig;

    // Maximum level among eligible sources (eligible levels are always > 0).
    always_comb begin
        w_maxlvl = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (w_elig[i] && (int_level[i*LVL_W +: LVL_W] > w_maxlvl)) begin
                w_maxlvl = int_level[i*LVL_W +: LVL_W];
            end
        end
    end

    // Candidates tied at the maximum level; highest set index is the fixed winner.
    always_comb begin
        w_cand  = '0;
        w_hi_id = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_cand[i] = w_elig[i] && (int_level[i*LVL_W +: LVL_W] == w_maxlvl);
            if (w_cand[i]) begin
                w_hi_id = ID_W'(i);
            end
        end
    end

`ifdef CLIC_ARB_RR_EN
    // Round-robin: prefer the highest candidate below the last accepted id, else wrap.
    always_comb begin
        w_lo    = '0;
        w_lo_id = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_lo[i] = w_cand[i] && (ID_W'(i) < r_last_id);
            if (w_lo[i]) begin
                w_lo_id = ID_W'(i);
            end
        end
        w_win_id = (|w_lo) ? w_lo_id : w_hi_id;
    end
`else
    assign w_win_id = w_hi_id;
`endif

    // One-hot form of the selected winner.
    always_comb begin
        w_win_oh = '0;
        w_win_oh[w_win_id] = 1'b1;
    end

    // Retract and preempt conditions evaluated against the latched winner.
    always_comb begin
        w_lat_elig = |(w_elig & r_onehot);
        w_preempt  = 1'b0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (w_elig[i] && (int_level[i*LVL_W +: LVL_W] > r_lvl)) begin
                w_preempt = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clic_clk or posedge clic_rst) begin
        if (clic_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; in REQ, ack beats retract, which beats preempt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                w_state_nxt = w_any_elig ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                if (core_ack)         w_state_nxt = S_CLAIM;
                else if (!w_lat_elig) w_state_nxt = S_SCAN;
                else if (w_preempt)   w_state_nxt = S_SCAN;
            end
            S_CLAIM: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the winner at the end of a successful scan; held through REQ and CLAIM.
    always_ff @(posedge clic_clk or posedge clic_rst) begin
        if (clic_rst) begin
            r_id     <= '0;
            r_lvl    <= '0;
            r_onehot <= '0;
        end else if ((r_state == S_SCAN) && w_any_elig) begin
            r_id     <= w_win_id;
            r_lvl    <= w_maxlvl;
            r_onehot <= w_win_oh;
        end
    end

`ifdef CLIC_ARB_RR_EN
    // Remember the most recently accepted id to rotate ties.
    always_ff @(posedge clic_clk or posedge clic_rst) begin
        if (clic_rst) begin
            r_last_id <= '0;
        end else if ((r_state == S_REQ) && core_ack) begin
            r_last_id <= r_id;
        end
    end
`endif

    // Outputs decoded from state so reset drops them immediately.
    always_comb begin
        arb_req_vld    = (r_state == S_REQ);
        arb_busy       = (r_state != S_IDLE);
        arb_req_id     = r_id;
        arb_req_lvl    = r_lvl;
        core_claim_clr = (r_state == S_CLAIM) ? r_onehot : '0;
    end

endmodule

// File: tb/tb_cr_clic_arb_sched.sv
// Directed bench for cr_clic_arb_sched (NUM_INT=32, LVL_W=8, ID_W=5).
// Expected ids/levels/clear masks are hand-computed per vector.

module tb_cr_clic_arb_sched;

    localparam int NUM_INT = 32;
    localparam int LVL_W   = 8;
    localparam int ID_W    = 5;

    logic                     clk;
    logic                     rst;
    logic [NUM_INT-1:0]       pend;
    logic [NUM_INT-1:0]       en;
    logic [NUM_INT*LVL_W-1:0] lvl;
    logic [LVL_W-1:0]         thr;
    logic                     ack;
    logic                     vld;
    logic [ID_W-1:0]          id;
    logic [LVL_W-1:0]         rlvl;
    logic [NUM_INT-1:0]       clr;
    logic                     busy;

    int n_vec;
    int n_err;

    cr_clic_arb_sched #(.NUM_INT(NUM_INT), .LVL_W(LVL_W), .ID_W(ID_W)) dut (
        .clic_clk       (clk),
        .clic_rst       (rst),
        .int_pending    (pend),
        .int_enable     (en),
        .int_level      (lvl),
        .int_thresh     (thr),
        .arb_req_vld    (vld),
        .arb_req_id     (id),
        .arb_req_lvl    (rlvl),
        .core_ack       (ack),
        .core_claim_clr (clr),
        .arb_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [7:0] l);
        pend[idx] = 1'b1;
        en[idx]   = 1'b1;
        lvl[idx*LVL_W +: LVL_W] = l;
    endtask

    task automatic clr_all();
        pend = '0;
        en   = '0;
        lvl  = '0;
    endtask

    // Elig already applied in IDLE: SCAN after one edge, REQ after the second.
    task automatic to_req(input string tag, input logic [4:0] eid, input logic [7:0] elvl);
        tick();
        chk({tag, "_scan_vld"}, 64'(vld), 64'd0);
        tick();
        chk({tag, "_vld"}, 64'(vld), 64'd1);
        chk({tag, "_id"},  64'(id),  64'(eid));
        chk({tag, "_lvl"}, 64'(rlvl), 64'(elvl));
    endtask

    // Ack in REQ, check the one-cycle clear, then back to IDLE.
    task automatic do_ack(input string tag, input logic [4:0] eid, input bit drop_all);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_clr"}, 64'(clr), 64'(32'h1 << eid));
        chk({tag, "_claim_vld"}, 64'(vld), 64'd0);
        if (drop_all) clr_all();
        tick();
        chk({tag, "_clr_gone"}, 64'(clr), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [4:0] rr_exp [4];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ack = 1'b0;
        thr = '0;
        clr_all();
        tick();
        tick();
        chk("rst_vld",  64'(vld),  64'd0);
        chk("rst_id",   64'(id),   64'd0);
        chk("rst_lvl",  64'(rlvl), 64'd0);
        chk("rst_clr",  64'(clr),  64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // T2 basic
        set_src(3, 8'd5);
        thr = 8'd2;
        tick();
        chk("t2_scan_busy", 64'(busy), 64'd1);
        chk("t2_scan_vld",  64'(vld),  64'd0);
        tick();
        chk("t2_vld", 64'(vld),  64'd1);
        chk("t2_id",  64'(id),   64'd3);
        chk("t2_lvl", 64'(rlvl), 64'd5);
        do_ack("t2", 5'd3, 1'b1);

        // T3 level wins over index, then tie on highest index
        thr = 8'd0;
        set_src(1, 8'd9);
        set_src(7, 8'd4);
        to_req("t3a", 5'd1, 8'd9);
        do_ack("t3a", 5'd1, 1'b1);
        set_src(2, 8'd9);
        set_src(6, 8'd9);
        to_req("t3b", 5'd6, 8'd9);
        do_ack("t3b", 5'd6, 1'b1);

        // T4 equal newcomer holds, higher level preempts, retract drops with no claim
        set_src(2, 8'd4);
        to_req("t4a", 5'd2, 8'd4);
        set_src(3, 8'd4);
        tick();
        chk("t4_eq_vld", 64'(vld), 64'd1);
        chk("t4_eq_id",  64'(id),  64'd2);
        pend[3] = 1'b0;
        set_src(5, 8'd8);
        tick();
        chk("t4_pre_vld", 64'(vld), 64'd0);
        chk("t4_pre_clr", 64'(clr), 64'd0);
        tick();
        chk("t4_pre_vld2", 64'(vld),  64'd1);
        chk("t4_pre_id",   64'(id),   64'd5);
        chk("t4_pre_lvl",  64'(rlvl), 64'd8);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t4_pre_clr5", 64'(clr), 64'h20);
        pend[5] = 1'b0;
        tick();
        chk("t4_back_idle", 64'(busy), 64'd0);
        to_req("t4b", 5'd2, 8'd4);
        pend[2] = 1'b0;
        tick();
        chk("t4_ret_vld", 64'(vld), 64'd0);
        chk("t4_ret_clr", 64'(clr), 64'd0);
        tick();
        chk("t4_ret_idle", 64'(busy), 64'd0);
        chk("t4_ret_clr2", 64'(clr),  64'd0);
        clr_all();

        // T5 ack in the same cycle the source drops; then thresh all-ones
        set_src(4, 8'd7);
        to_req("t5", 5'd4, 8'd7);
        ack = 1'b1;
        pend[4] = 1'b0;
        tick();
        ack = 1'b0;
        chk("t5_race_clr", 64'(clr), 64'h10);
        tick();
        chk("t5_race_idle", 64'(busy), 64'd0);
        clr_all();
        thr = 8'hFF;
        set_src(10, 8'hFF);
        set_src(11, 8'h80);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_thr_vld",  64'(vld),  64'd0);
            chk("t5_thr_busy", 64'(busy), 64'd0);
        end
        clr_all();
        thr = 8'd0;

        // T1 reset mid-REQ
        set_src(2, 8'd3);
        to_req("t1", 5'd2, 8'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_vld",  64'(vld),  64'd0);
        chk("t1_id",   64'(id),   64'd0);
        chk("t1_lvl",  64'(rlvl), 64'd0);
        chk("t1_clr",  64'(clr),  64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        clr_all();
        tick();
        rst = 1'b0;
        tick();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_vld",  64'(vld),  64'd0);

        // T6 tie between src4 and src9, ack every request
`ifdef CLIC_ARB_RR_EN
        rr_exp[0] = 5'd9; rr_exp[1] = 5'd4; rr_exp[2] = 5'd9; rr_exp[3] = 5'd4;
`else
        rr_exp[0] = 5'd9; rr_exp[1] = 5'd9; rr_exp[2] = 5'd9; rr_exp[3] = 5'd9;
`endif
        set_src(4, 8'd3);
        set_src(9, 8'd3);
        for (int k = 0; k < 4; k++) begin
            to_req("t6", rr_exp[k], 8'd3);
            do_ack("t6", rr_exp[k], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
